uart_tx_fifo: RTL and testbench

// - UART transmitter for the calculator Top: serialises result bytes onto the Tx line.
// - Counterpart to the existing Rx path: 8N1 framing, LSB first, 16x oversample tick.
// - Bit period is 624 clk.
// - Small FIFO decouples result producers from the slow serial line.
// - Multi-character replies queue without stalling the core.

---
 rtl/uart_tx_fifo.sv | 209 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// UART transmitter with a small byte FIFO in front of it. Each byte goes out as
// one frame: a start bit, DBIT data bits LSB first, an optional parity bit and
// a stop bit. Every bit lasts CLK_DIV*SB_TICK clk.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high
//   tx_data   byte to send, sampled when tx_wr=1
//   tx_wr     one-cycle write strobe into the FIFO
//   tx_full   FIFO full; writes are dropped while high
//   tx_empty  FIFO empty
//   tx_busy   a frame is in progress
//   tx_done   one-cycle pulse in the last clk of every stop bit
//   Tx        serial line, idle high, driven from a register
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between
// the data bits and the stop bit. Without it the framing is 8N1.
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | even parity bit (UART_TX_PARITY_EN builds only)
// STOP   | stop bit (high); the next queued byte follows with no gap

module uart_tx_fifo #(
  parameter int CLK_DIV = 39,
  parameter int SB_TICK = 16,
  parameter int DBIT    = 8,
  parameter int FIFO_AW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DBIT-1:0] tx_data,
  input  logic            tx_wr,
  output logic            tx_full,
  output logic            tx_empty,
  output logic            tx_busy,
  output logic            tx_done,
  output logic            Tx
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int SW = $clog2(SB_TICK);
  localparam int NW = $clog2(DBIT);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(CLK_DIV - 2);
  localparam logic [SW-1:0] S_LAST   = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST   = NW'(DBIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state;
  logic [DW-1:0]       div_cnt;
  logic [SW-1:0]       s_cnt;
  logic [NW-1:0]       n_cnt;
  logic [DBIT-1:0]     shreg;
  logic [DBIT-1:0]     mem [2**FIFO_AW];
  logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
  logic [DBIT-1:0]     head;
  logic                tick, s_last, wr_en, pop;
`ifdef UART_TX_PARITY_EN
  logic                parity_bit;
`endif

  assign head   = mem[rd_ptr];
  assign tick   = (div_cnt == DIV_LAST);
  assign s_last = (s_cnt == S_LAST);
  assign wr_en  = tx_wr && !tx_full;
  // Pop either to start from idle or to chain straight off the end of a stop bit.
  assign pop    = !tx_empty && ((state == IDLE) || (state == STOP && tick && s_last));

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_full  <= 1'b0;
      tx_empty <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10: begin
          tx_empty <= 1'b0;
          tx_full  <= ((wr_ptr + 1'b1) == rd_ptr);
        end
        2'b01: begin
          tx_full  <= 1'b0;
          tx_empty <= ((rd_ptr + 1'b1) == wr_ptr);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      s_cnt   <= '0;
      n_cnt   <= '0;
      shreg   <= '0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      Tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      // Divider parked at zero in IDLE so each frame starts phase-aligned.
      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + 1'b1;

      case (state)
        IDLE: begin
          Tx <= 1'b1;
          if (pop) begin
            shreg   <= head;
            s_cnt   <= '0;
            state   <= START;
            tx_busy <= 1'b1;
            Tx      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^head;
`endif
          end
        end
        START: begin
          if (tick) begin
            if (s_last) begin
              s_cnt <= '0;
              n_cnt <= '0;
              state <= DATA;
              Tx    <= shreg[0];
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s_last) begin
              s_cnt <= '0;
              shreg <= shreg >> 1;
              if (n_cnt == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                state <= PARITY;
                Tx    <= parity_bit;
`else
                state <= STOP;
                Tx    <= 1'b1;
`endif
              end else begin
                n_cnt <= n_cnt + 1'b1;
                Tx    <= shreg[1];
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (s_last) begin
              s_cnt <= '0;
              state <= STOP;
              Tx    <= 1'b1;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          // Registered pulse: raised one clk early so it lands in the stop bit's last clk.
          if (s_last && div_cnt == DIV_PRE) tx_done <= 1'b1;
          if (tick) begin
            if (s_last) begin
              s_cnt <= '0;
              if (pop) begin
                shreg <= head;
                state <= START;
                Tx    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                parity_bit <= ^head;
`endif
              end else begin
                state   <= IDLE;
                tx_busy <= 1'b0;
                Tx      <= 1'b1;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. Stimulus pushes the bytes it expects on the line
// into a queue; a line decoder samples each frame at mid-bit and compares it
// against the queue head. Timing, flag and reset behaviour are checked inline.

module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 6864;
`else
  localparam int FRAME = 6240;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_full, tx_empty, tx_busy, tx_done, Tx;

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_wr(tx_wr),
    .tx_full(tx_full), .tx_empty(tx_empty), .tx_busy(tx_busy),
    .tx_done(tx_done), .Tx(Tx)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt = 0;
  always @(negedge clk) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

  int         checks = 0;
  int         passed = 0;
  logic [7:0] exp_q[$];
  int         starts[$];
  logic       mon_abort;

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
  endtask

  task automatic mon_wait(input int n);
    for (int i = 0; i < n && !mon_abort; i++) begin
      @(negedge clk);
      if (reset) mon_abort = 1'b1;
    end
  endtask

  // Line decoder / scoreboard consumer.
  initial begin
    logic [7:0] b;
    logic [7:0] e;
    logic       par;
    mon_abort = 1'b0;
    b = '0;
    par = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && Tx === 1'b0) begin
        mon_abort = 1'b0;
        starts.push_back(cyc);
        mon_wait(311);
        if (!mon_abort) check("start_bit_mid", int'(Tx), 0);
        for (int i = 0; i < 8; i++) begin
          mon_wait(624);
          b[i] = Tx;
        end
`ifdef UART_TX_PARITY_EN
        mon_wait(624);
        par = Tx;
`endif
        mon_wait(624);
        if (!mon_abort) begin
          check("stop_bit", int'(Tx), 1);
          check("frame_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("frame_byte", int'(b), int'(e));
`ifdef UART_TX_PARITY_EN
            check("parity_bit", int'(par), int'(^e));
`endif
          end
        end
        mon_wait(312);
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] d);
    tx_data = d;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((tx_busy || !tx_empty) && n < 40000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40000) check("idle_timeout", n, 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int w, d0, s0, bad;
    reset = 1'b1;
    tx_wr = 1'b0;
    tx_data = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", int'(Tx), 1);
    check("rst_full", int'(tx_full), 0);
    check("rst_empty", int'(tx_empty), 1);
    check("rst_busy", int'(tx_busy), 0);
    check("rst_done", int'(tx_done), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 0x38, timing of start, bit boundary and tx_done.
    w  = cyc;
    d0 = done_cnt;
    exp_q.push_back(8'h38);
    wr(8'h38);
    check("t2_empty_w1", int'(tx_empty), 0);
    check("t2_tx_w1", int'(Tx), 1);
    wait_cyc(w + 2);
    check("t2_tx_start", int'(Tx), 0);
    check("t2_busy", int'(tx_busy), 1);
    check("t2_empty_popped", int'(tx_empty), 1);
    wait_cyc(w + 625);
    check("t2_tx_start_end", int'(Tx), 0);
    wait_cyc(w + 2497);
    check("t2_bit2", int'(Tx), 0);
    wait_cyc(w + 2498);
    check("t2_bit3", int'(Tx), 1);
    wait_cyc(w + FRAME);
    check("t2_done_early", int'(tx_done), 0);
    wait_cyc(w + FRAME + 1);
    check("t2_done_pulse", int'(tx_done), 1);
    check("t2_tx_stop", int'(Tx), 1);
    wait_cyc(w + FRAME + 2);
    check("t2_done_clear", int'(tx_done), 0);
    check("t2_busy_end", int'(tx_busy), 0);
    repeat (2) @(negedge clk);
    check("t2_done_count", done_cnt - d0, 1);

    // Three back-to-back bytes.
    wait_idle();
    w  = cyc;
    d0 = done_cnt;
    s0 = starts.size();
    exp_q.push_back(8'h37);
    exp_q.push_back(8'h2A);
    exp_q.push_back(8'h39);
    wr(8'h37);
    wr(8'h2A);
    wr(8'h39);
    wait_cyc(w + 2);
    bad = 0;
    while (cyc <= w + 1 + 3 * FRAME) begin
      if (tx_busy !== 1'b1) bad++;
      @(negedge clk);
    end
    check("t3_busy_gaps", bad, 0);
    repeat (3) @(negedge clk);
    check("t3_done_count", done_cnt - d0, 3);
    check("t3_frame_count", starts.size() - s0, 3);
    if (starts.size() - s0 == 3) begin
      check("t3_first_start", starts[s0], w + 2);
      check("t3_gap1", starts[s0 + 1] - starts[s0], FRAME);
      check("t3_gap2", starts[s0 + 2] - starts[s0 + 1], FRAME);
    end

    // Overfill: sixth byte dropped.
    wait_idle();
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h30 + i));
    for (int i = 0; i < 6; i++) begin
      if (i == 5) check("t4_full", int'(tx_full), 1);
      wr(8'(8'h30 + i));
    end
    check("t4_still_full", int'(tx_full), 1);
    wait_idle();
    check("t4_full_clear", int'(tx_full), 0);
    check("t4_queue_drained", exp_q.size(), 0);

    // Write after drain: empty low for exactly one cycle.
    w = cyc;
    exp_q.push_back(8'h33);
    wr(8'h33);
    check("t5_empty_w1", int'(tx_empty), 0);
    @(negedge clk);
    check("t5_empty_w2", int'(tx_empty), 1);
    wait_idle();
    check("t5_queue_drained", exp_q.size(), 0);

    // Reset mid-frame with bytes still queued.
    d0 = done_cnt;
    wr(8'h55);
    wr(8'h56);
    repeat (500) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t1_tx_async", int'(Tx), 1);
    check("t1_busy_async", int'(tx_busy), 0);
    check("t1_empty_async", int'(tx_empty), 1);
    check("t1_full_async", int'(tx_full), 0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (Tx !== 1'b1) bad++;
    end
    check("t1_line_idle", bad, 0);
    check("t1_no_done", done_cnt - d0, 0);
    check("t1_empty_after", int'(tx_empty), 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
